// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: flag-based condition evaluation, redirect/flush generation,
// 2-bit BHT direction predictor (enabled by BRANCH_PREDICT_EN) and branch performance counters.
module branch_resolver #(
   parameter int BHT_ENTRIES = 16,
   parameter int XLEN        = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic            ex_is_jump,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic            zero,
   input  logic            sf,
   input  logic            cf,
   input  logic            vf,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic [31:0]     branch_count,
   output logic [31:0]     mispredict_count
);

   localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

   function automatic logic cond_met(input logic [2:0] f3, input logic z, input logic s,
                                     input logic c, input logic v);
      case (f3)
         3'b000:  cond_met = z;
         3'b001:  cond_met = !z;
         3'b100:  cond_met = (s != v);
         3'b101:  cond_met = (s == v);
         3'b110:  cond_met = !c;
         3'b111:  cond_met = c;
         default: cond_met = 1'b0;
      endcase
   endfunction

   function automatic logic funct3_legal(input logic [2:0] f3);
      funct3_legal = (f3[2:1] != 2'b01);
   endfunction

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      sat_inc = (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      sat_dec = (c == 2'b00) ? c : c - 2'b01;
   endfunction

   logic            redirect_vld_p1;
   logic [XLEN-1:0] redirect_pc_p1;
   logic [31:0]     branch_count_p1;
   logic [31:0]     mispredict_count_p1;

   logic            resolve_p0;
   logic            jump_p0;
   logic            branch_p0;
   logic            taken_p0;
   logic            mispred_p0;
   logic            redirect_p0;
   logic [XLEN-1:0] pc_plus4_p0;
   logic [XLEN-1:0] next_pc_p0;

   // Stage p0: resolve the EX instruction; anything arriving while a redirect is out is wrong-path
   always_comb begin
      resolve_p0  = ex_valid && (ex_is_branch || ex_is_jump) && !redirect_vld_p1;
      jump_p0     = resolve_p0 && ex_is_jump;
      branch_p0   = resolve_p0 && !ex_is_jump && funct3_legal(ex_funct3);
      taken_p0    = cond_met(ex_funct3, zero, sf, cf, vf);
      mispred_p0  = branch_p0 && (taken_p0 != ex_pred_taken);
      redirect_p0 = jump_p0 || mispred_p0;
      pc_plus4_p0 = ex_pc + XLEN'(4);
      next_pc_p0  = (jump_p0 || taken_p0) ? ex_target : pc_plus4_p0;
   end

   // Stage p1: registered redirect and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_vld_p1     <= 1'b0;
         redirect_pc_p1      <= '0;
         branch_count_p1     <= '0;
         mispredict_count_p1 <= '0;
      end else begin
         redirect_vld_p1 <= redirect_p0;
         if (redirect_p0)
            redirect_pc_p1 <= next_pc_p0;
         if (branch_p0)
            branch_count_p1 <= branch_count_p1 + 32'd1;
         if (mispred_p0)
            mispredict_count_p1 <= mispredict_count_p1 + 32'd1;
      end
   end

   assign redirect_valid   = redirect_vld_p1;
   assign flush            = redirect_vld_p1;
   assign redirect_pc      = redirect_pc_p1;
   assign branch_count     = branch_count_p1;
   assign mispredict_count = mispredict_count_p1;

   logic unused_pc_bits;
   assign unused_pc_bits = ^if_pc;

`ifdef BRANCH_PREDICT_EN
   logic [1:0]       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;

   assign rd_idx = if_pc[IDX_W+1:2];
   assign wr_idx = ex_pc[IDX_W+1:2];
   // Read is pre-update: a same-index write lands only at the clock edge
   assign if_pred_taken = bht[rd_idx][1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= 2'b01;
      end else if (branch_p0) begin
         bht[wr_idx] <= taken_p0 ? sat_inc(bht[wr_idx]) : sat_dec(bht[wr_idx]);
      end
   end
`else
   logic [1:0] unused_sat;
   assign unused_sat    = sat_inc(2'b00) ^ sat_dec(2'b11);
   assign if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: behavioural reference model checked every cycle,
// plus hand-computed literal expectations along the stimulus sequence.
module tb_branch_resolver;

`ifdef BRANCH_PREDICT_EN
   localparam logic BP = 1'b1;
`else
   localparam logic BP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        ex_valid, ex_is_branch, ex_is_jump;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_target;
   logic        ex_pred_taken;
   logic        zero, sf, cf, vf;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [31:0] branch_count, mispredict_count;

   int tests = 0;
   int fails = 0;

   branch_resolver #(.BHT_ENTRIES(16), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
      .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .zero(zero), .sf(sf), .cf(cf), .vf(vf),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic        m_on = 1'b0;
   logic        m_rv;
   logic [31:0] m_rpc;
   logic [31:0] m_bc, m_mc;
   int          m_bht [16];

   function automatic logic outcome(input logic [2:0] f3, input logic z, input logic s,
                                    input logic c, input logic v);
      logic r;
      r = 1'b0;
      if (f3 == 3'd0) r = z;             // equal
      if (f3 == 3'd1) r = ~z;            // not equal
      if (f3 == 3'd4) r = s ^ v;         // signed less-than
      if (f3 == 3'd5) r = ~(s ^ v);      // signed greater-or-equal
      if (f3 == 3'd6) r = ~c;            // unsigned less-than (borrow)
      if (f3 == 3'd7) r = c;             // unsigned greater-or-equal
      return r;
   endfunction

   always @(posedge clk) begin : model
      logic        nrv, t;
      logic [31:0] nrpc, nbc, nmc;
      int          idx;
      if (rst) begin
         m_on  <= 1'b1;
         m_rv  <= 1'b0;
         m_rpc <= 32'd0;
         m_bc  <= 32'd0;
         m_mc  <= 32'd0;
         for (int i = 0; i < 16; i++) m_bht[i] <= 1;
      end else if (m_on) begin
         nrv = 1'b0; nrpc = m_rpc; nbc = m_bc; nmc = m_mc;
         idx = int'((ex_pc / 4) % 16);
         if (ex_valid && (ex_is_branch || ex_is_jump) && !m_rv) begin
            if (ex_is_jump) begin
               nrv = 1'b1; nrpc = ex_target;
            end else if (ex_funct3 != 3'd2 && ex_funct3 != 3'd3) begin
               t   = outcome(ex_funct3, zero, sf, cf, vf);
               nbc = m_bc + 1;
               if (t) m_bht[idx] <= (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
               else   m_bht[idx] <= (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
               if (t != ex_pred_taken) begin
                  nmc = m_mc + 1; nrv = 1'b1;
                  nrpc = t ? ex_target : ex_pc + 32'd4;
               end
            end
         end
         m_rv <= nrv; m_rpc <= nrpc; m_bc <= nbc; m_mc <= nmc;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      if (m_on) begin
         chk("mdl_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
         chk("mdl_flush", {31'd0, flush}, {31'd0, m_rv});
         if (m_rv) chk("mdl_redirect_pc", redirect_pc, m_rpc);
         chk("mdl_branch_count", branch_count, m_bc);
         chk("mdl_mispredict_count", mispredict_count, m_mc);
         chk("mdl_if_pred_taken", {31'd0, if_pred_taken},
             {31'd0, BP && (m_bht[int'((if_pc / 4) % 16)] >= 2)});
      end
   end

   task automatic issue(input logic br, input logic jmp, input logic [2:0] f3,
                        input logic z, input logic s, input logic c, input logic v,
                        input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
      ex_valid = 1'b1; ex_is_branch = br; ex_is_jump = jmp; ex_funct3 = f3;
      zero = z; sf = s; cf = c; vf = v; ex_pred_taken = pred; ex_pc = pc; ex_target = tgt;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
      ex_funct3 = '0; ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0;
      zero = 1'b0; sf = 1'b0; cf = 1'b0; vf = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_branch_count", branch_count, 32'd0);
      chk("rst_mispredict_count", mispredict_count, 32'd0);

      // BEQ taken, predicted not-taken
      issue(1, 0, 3'd0, 1, 0, 0, 0, 0, 32'h100, 32'h140);
      chk("beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      chk("beq_flush", {31'd0, flush}, 32'd1);
      chk("beq_redirect_pc", redirect_pc, 32'h140);
      chk("beq_branch_count", branch_count, 32'd1);
      chk("beq_mispredict_count", mispredict_count, 32'd1);
      idle();
      chk("beq_redirect_drop", {31'd0, redirect_valid}, 32'd0);
      chk("beq_flush_drop", {31'd0, flush}, 32'd0);

      // BLT and BGEU back-to-back, both correctly predicted taken
      issue(1, 0, 3'd4, 0, 1, 0, 0, 1, 32'h300, 32'h340);
      issue(1, 0, 3'd7, 0, 0, 1, 0, 1, 32'h304, 32'h380);
      chk("blt_bgeu_no_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("blt_bgeu_branch_count", branch_count, 32'd3);
      chk("blt_bgeu_mispredict_count", mispredict_count, 32'd1);
      // BLTU not taken (cf=1) but predicted taken -> fall through
      issue(1, 0, 3'd6, 0, 0, 1, 0, 1, 32'h200, 32'h280);
      chk("bltu_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      chk("bltu_redirect_pc", redirect_pc, 32'h204);
      chk("bltu_mispredict_count", mispredict_count, 32'd2);
      idle();

      // BHT saturation at index 14
      if_pc = 32'h438; #1;
      chk("bht_init_weak_nt", {31'd0, if_pred_taken}, 32'd0);
      issue(1, 0, 3'd0, 1, 0, 0, 0, 1, 32'h438, 32'h500);
      chk("bht_after_1_taken", {31'd0, if_pred_taken}, {31'd0, BP});
      issue(1, 0, 3'd0, 1, 0, 0, 0, 1, 32'h438, 32'h500);
      issue(1, 0, 3'd0, 1, 0, 0, 0, 1, 32'h438, 32'h500);
      chk("bht_after_3_taken", {31'd0, if_pred_taken}, {31'd0, BP});
      issue(1, 0, 3'd0, 0, 0, 0, 0, 0, 32'h438, 32'h500);
      chk("bht_after_1_nt", {31'd0, if_pred_taken}, {31'd0, BP});
      issue(1, 0, 3'd0, 0, 0, 0, 0, 0, 32'h438, 32'h500);
      chk("bht_after_2_nt", {31'd0, if_pred_taken}, 32'd0);
      issue(1, 0, 3'd0, 0, 0, 0, 0, 0, 32'h438, 32'h500);
      chk("bht_counts", branch_count, 32'd10);
      // 00 + one taken must still read not-taken
      issue(1, 0, 3'd0, 1, 0, 0, 0, 0, 32'h438, 32'h500);
      chk("bht_floor_then_taken", {31'd0, if_pred_taken}, 32'd0);
      idle();

      // Mispredict followed by a wrong-path mispredict
      issue(1, 0, 3'd1, 0, 0, 0, 0, 0, 32'h500, 32'h600);
      chk("bne_redirect_pc", redirect_pc, 32'h600);
      issue(1, 0, 3'd1, 0, 0, 0, 0, 0, 32'h504, 32'h700);
      chk("wrongpath_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("wrongpath_branch_count", branch_count, 32'd12);
      chk("wrongpath_mispredict_count", mispredict_count, 32'd4);
      idle();

      // JAL, then branch+jump both set, then illegal funct3
      issue(0, 1, 3'd0, 0, 0, 0, 0, 1, 32'h700, 32'h80);
      chk("jal_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      chk("jal_redirect_pc", redirect_pc, 32'h80);
      chk("jal_branch_count", branch_count, 32'd12);
      idle();
      issue(1, 1, 3'd0, 1, 0, 0, 0, 0, 32'h438, 32'h90);
      chk("brjmp_redirect_pc", redirect_pc, 32'h90);
      chk("brjmp_bht_untouched", {31'd0, if_pred_taken}, 32'd0);
      chk("brjmp_branch_count", branch_count, 32'd12);
      idle();
      issue(1, 0, 3'd2, 1, 0, 0, 0, 1, 32'h438, 32'h99);
      issue(1, 0, 3'd3, 0, 0, 0, 0, 0, 32'h438, 32'h99);
      chk("f3_illegal_no_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("f3_illegal_branch_count", branch_count, 32'd12);
      chk("f3_illegal_mispredict_count", mispredict_count, 32'd4);

      // Reset during the redirect cycle
      if_pc = 32'h100; #1;
      chk("idx0_pred_before_rst", {31'd0, if_pred_taken}, {31'd0, BP});
      issue(1, 0, 3'd0, 1, 0, 0, 0, 0, 32'h600, 32'h800);
      chk("pre_rst_redirect_pc", redirect_pc, 32'h800);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("midrst_branch_count", branch_count, 32'd0);
      chk("midrst_mispredict_count", mispredict_count, 32'd0);
      for (int i = 0; i < 16; i++) begin
         if_pc = 32'(i * 4); #1;
         chk("midrst_bht_weak_nt", {31'd0, if_pred_taken}, 32'd0);
      end
      idle();
      idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage consumer of the ALU condition flags (zero, sf, cf, vf) produced by the compare-subtract (sel = 4'b0110) for RV32I conditional branches. It turns the flags plus funct3 into a resolved taken/not-taken outcome and compares that outcome with the direction predicted at fetch. On a mismatch it issues a registered, one-cycle redirect/flush to fetch. It also holds the direction predictor (2-bit BHT) that fetch queries, and performance counters.

## Interface
Parameters:
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, indexed by PC[log2(BHT_ENTRIES)+1:2]
- XLEN, 32, address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  XLEN  fetch PC for prediction lookup
- if_pred_taken  out  1  combinational: MSB of BHT[if_pc index]
- ex_valid  in  1  EX stage holds a live instruction
- ex_is_branch  in  1  B-type instruction
- ex_is_jump  in  1  JAL/JALR
- ex_funct3  in  3  branch condition
- ex_pc  in  XLEN  PC of the EX instruction
- ex_target  in  XLEN  computed taken target
- ex_pred_taken  in  1  direction used at fetch, carried down the pipe
- zero, sf, cf, vf  in  1 each  ALU flags for the EX instruction (A−B)
- redirect_valid  out  1  registered; fetch must load redirect_pc
- redirect_pc  out  XLEN  registered correct next PC
- flush  out  1  registered; equals redirect_valid; squashes IF/ID and ID/EX
- branch_count  out  32  resolved conditional branches
- mispredict_count  out  32  conditional-branch mispredictions

## Operation
- Condition per funct3: 000 BEQ zero; 001 BNE !zero; 100 BLT sf!=vf; 101 BGE sf==vf; 110 BLTU !cf; 111 BGEU cf. 010/011 → not taken, no redirect, no counter or BHT change.
- Resolve event: ex_valid & (ex_is_branch | ex_is_jump) & !redirect_valid. Any EX instruction in the cycle redirect_valid=1 is wrong-path and is ignored.
- Branch: mispredict = taken != ex_pred_taken. On mispredict: redirect_pc = taken ? ex_target : ex_pc+4 (modulo 2^XLEN).
- Jump: always redirect to ex_target. ex_pred_taken is ignored. No BHT update, no counter update.
- BHT update on a branch resolve: taken → saturating increment (max 2'b11); not taken → saturating decrement (min 2'b00).
- Counters: branch_count +1 per resolved legal branch; mispredict_count +1 per branch mispredict. Both wrap 0xFFFFFFFF→0.
- Simultaneous lookup and update at the same index: if_pred_taken returns the pre-update value.
- ex_is_branch & ex_is_jump both set: treated as a jump.

## Timing
- Resolve in cycle N → redirect_valid/flush high in cycle N+1, for exactly one cycle. redirect_pc is valid in the same cycle. BHT and counters update at the end of cycle N.
- Back-to-back resolves without redirect: each resolves independently, no bubbles.
- Reset values: redirect_valid=0, flush=0, redirect_pc=0, branch_count=0, mispredict_count=0, all BHT entries=2'b01 (weakly not-taken).
- Reset mid-operation: rst asserted in cycle N+1 of a pending redirect drops redirect_valid in N+2. The redirect is lost.
- if_pred_taken: zero-cycle combinational path from if_pc.

## Configuration
- BRANCH_PREDICT_EN defined: BHT is instantiated and behaves as above.
- BRANCH_PREDICT_EN undefined: no BHT storage; if_pred_taken is tied 0 (static not-taken); redirect and counter logic are unchanged, so every taken branch is counted as a mispredict.

## Test plan
- Reset then BEQ with zero=1, ex_pred_taken=0, ex_pc=0x100, ex_target=0x140 → next cycle redirect_valid=1, redirect_pc=0x140, flush=1; following cycle both are 0; mispredict_count=1, branch_count=1.
- BLT with sf=1, vf=0 and BGEU with cf=1, each with ex_pred_taken=1 → no redirect, branch_count=2, mispredict_count=0. BLTU with cf=1, ex_pred_taken=1, ex_pc=0x200 → redirect_pc=0x204.
- Branch at the same PC resolved taken 3 times → BHT entry 01→10→11→11 and if_pred_taken=1. Then 3 not-taken → 11→10→01→00.
- Mispredicting branch in cycle N, then a valid mispredicting branch in N+1 → that second branch is ignored: redirect_valid stays high for 1 cycle only and counters rise by 1.
- JAL with ex_target=0x80 → redirect_pc=0x80, branch_count and the BHT unchanged. funct3=010 branch → no effect.
- mispredict_count preset to 0xFFFFFFFF by forcing 2^32−1 mispredicts (or by backdoor load), then one more mispredict → 0. Also rst in the redirect cycle → redirect_valid=0 on the next cycle and all BHT entries read as 01.
